// File: rtl/ctrl_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_types_pkg
// Description : Request opcode type and decoder shared by the cache memory block.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_types_pkg;

    typedef enum logic [2:0] {
        NOP       = 3'd0,
        KEY_WRITE = 3'd1,
        IDX_WRITE = 3'd2,
        DELETE    = 3'd3,
        ILLEGAL   = 3'd4
    } mem_op_e;

    // Delete ignores select: it is always index-addressed.
    function automatic mem_op_e decode_op(input logic wr, input logic sel, input logic del);
        mem_op_e op;
        if (wr && del)     op = ILLEGAL;
        else if (wr)       op = sel ? IDX_WRITE : KEY_WRITE;
        else if (del)      op = DELETE;
        else               op = NOP;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/first_set_enc.sv
`default_nettype none
// ============================================================================
// Module      : first_set_enc
// Description : One-hot encoder of the lowest set bit of a request vector.
// Revision    : 1.0 - initial release
// ============================================================================
module first_set_enc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic             any
);

    // Two's complement isolates the lowest set bit.
    assign onehot = req & (~req + WIDTH'(1));
    assign any    = |req;

endmodule
`default_nettype wire

// File: rtl/cache_mem_block.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_block
// Description : Small fully-associative key/value store with key and index access.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_block
    import ctrl_types_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [KEY_WIDTH-1:0]             key_in,
    input  logic [VALUE_WIDTH-1:0]           value_in,
    input  logic                             select,
    input  logic                             write_in,
    input  logic                             delete_in,
    input  logic [NUM_ENTRIES-1:0]           idx_in,
    output logic                             hit,
    output logic [NUM_ENTRIES-1:0]           hit_idx,
    output logic [VALUE_WIDTH-1:0]           value_out,
    output logic                             full,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] used_count,
    output logic                             error
);

    localparam int                c_cnt_w = $clog2(NUM_ENTRIES + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(NUM_ENTRIES);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [KEY_WIDTH-1:0]   r_key   [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] r_value [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [c_cnt_w-1:0]     r_used;
    logic                   r_error;

    logic [NUM_ENTRIES-1:0] w_match;
    logic [NUM_ENTRIES-1:0] w_free;
    logic                   w_free_any;
    logic                   w_idx_onehot;
    logic                   w_idx_valid;
    logic [NUM_ENTRIES-1:0] w_addr;
    mem_op_e                w_op;
    logic [NUM_ENTRIES-1:0] w_wr_mask;
    logic [NUM_ENTRIES-1:0] w_set_mask;
    logic [NUM_ENTRIES-1:0] w_clr_mask;
    logic                   w_inc;
    logic                   w_dec;
    logic                   w_reject;

    generate
        for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_match
            assign w_match[i] = r_valid[i] && (r_key[i] == key_in);
        end
    endgenerate

    first_set_enc #(.WIDTH(NUM_ENTRIES)) u_hit_enc (
        .req    (w_match),
        .onehot (hit_idx),
        .any    (hit)
    );

    first_set_enc #(.WIDTH(NUM_ENTRIES)) u_free_enc (
        .req    (~r_valid),
        .onehot (w_free),
        .any    (w_free_any)
    );

    assign w_idx_onehot = (idx_in != '0) && ((idx_in & (idx_in - NUM_ENTRIES'(1))) == '0);
    assign w_idx_valid  = |(idx_in & r_valid);
    assign w_op         = decode_op(write_in, select, delete_in);

    // Index reads only expose valid cells, so stale storage never leaks out.
    assign w_addr = select ? (w_idx_onehot ? (idx_in & r_valid) : '0) : hit_idx;

    always_comb begin
        value_out = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_addr[i]) value_out = value_out | r_value[i];
        end
    end

    always_comb begin
        w_wr_mask  = '0;
        w_set_mask = '0;
        w_clr_mask = '0;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        w_reject   = 1'b0;
        case (w_op)
            KEY_WRITE: begin
                if (hit) begin
                    w_wr_mask = hit_idx;
                end else if (w_free_any) begin
                    w_wr_mask  = w_free;
                    w_set_mask = w_free;
                    w_inc      = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
            end
            IDX_WRITE: begin
                if (w_idx_onehot) begin
                    w_wr_mask  = idx_in;
                    w_set_mask = idx_in;
                    w_inc      = !w_idx_valid;
                end else begin
                    w_reject = 1'b1;
                end
            end
            DELETE: begin
                if (w_idx_onehot && w_idx_valid) begin
                    w_clr_mask = idx_in;
                    w_dec      = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
            end
            ILLEGAL: w_reject = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_used  <= '0;
            r_error <= 1'b0;
        end else begin
            r_valid <= (r_valid | w_set_mask) & ~w_clr_mask;
            r_error <= w_reject;
            if (w_inc)      r_used <= r_used + c_one;
            else if (w_dec) r_used <= r_used - c_one;
        end
    end

    // Storage needs no reset: a cell is only observable while its valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_wr_mask[i]) begin
                r_key[i]   <= key_in;
                r_value[i] <= value_in;
            end
        end
    end

    assign full       = (r_used == c_full);
    assign used_count = r_used;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_block
// Description : Scoreboard bench for cache_mem_block against a key/value model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_block;

    localparam int N  = 16;
    localparam int KW = 8;
    localparam int VW = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KW-1:0] key_in = '0;
    logic [VW-1:0] value_in = '0;
    logic          select = 1'b0;
    logic          write_in = 1'b0;
    logic          delete_in = 1'b0;
    logic [N-1:0]  idx_in = '0;
    logic          hit;
    logic [N-1:0]  hit_idx;
    logic [VW-1:0] value_out;
    logic          full;
    logic [CW-1:0] used_count;
    logic          error;

    cache_mem_block #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .value_in   (value_in),
        .select     (select),
        .write_in   (write_in),
        .delete_in  (delete_in),
        .idx_in     (idx_in),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .value_out  (value_out),
        .full       (full),
        .used_count (used_count),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [N-1:0]  hit_idx;
        logic [VW-1:0] vout;
        logic          full;
        logic [CW-1:0] used_pre;
        logic          err;
        logic [CW-1:0] used_post;
        logic          full_post;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain arrays of key, value and occupancy.
    logic [KW-1:0] m_key   [N];
    logic [VW-1:0] m_val   [N];
    bit            m_valid [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic do_op(input bit wr, input bit del, input bit sel,
                         input logic [KW-1:0] key, input logic [VW-1:0] val,
                         input logic [N-1:0] idx);
        exp_t e;
        int   hp = -1;
        int   ip = -1;
        int   cnt;
        bit   onehot;
        bit   err = 1'b0;
        @(negedge clk);
        write_in = wr; delete_in = del; select = sel;
        key_in = key; value_in = val; idx_in = idx;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_key[i] == key) begin hp = i; break; end
        onehot = ($countones(idx) == 1);
        if (onehot) for (int i = 0; i < N; i++) if (idx[i]) ip = i;
        cnt        = m_count();
        e.hit      = (hp >= 0);
        e.hit_idx  = (hp >= 0) ? (N'(1) << hp) : '0;
        if (sel) e.vout = (onehot && m_valid[ip]) ? m_val[ip] : '0;
        else     e.vout = (hp >= 0) ? m_val[hp] : '0;
        e.full     = (cnt == N);
        e.used_pre = CW'(cnt);
        if (wr && del) begin
            err = 1'b1;
        end else if (wr && !sel) begin
            if (hp >= 0) begin
                m_val[hp] = val;
            end else if (cnt < N) begin
                for (int i = 0; i < N; i++) if (!m_valid[i]) begin
                    m_key[i] = key; m_val[i] = val; m_valid[i] = 1'b1; break;
                end
            end else begin
                err = 1'b1;
            end
        end else if (wr) begin
            if (onehot) begin m_key[ip] = key; m_val[ip] = val; m_valid[ip] = 1'b1; end
            else err = 1'b1;
        end else if (del) begin
            if (onehot && m_valid[ip]) m_valid[ip] = 1'b0;
            else err = 1'b1;
        end
        e.err       = err;
        e.used_post = CW'(m_count());
        e.full_post = (m_count() == N);
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        write_in = 1'b0; delete_in = 1'b0; select = 1'b0;
    endtask

    // Monitor: pre-edge combinational outputs, then the registered response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("hit",        32'(hit),        32'(e.hit));
                check("hit_idx",    32'(hit_idx),    32'(e.hit_idx));
                check("value_out",  32'(value_out),  32'(e.vout));
                check("full",       32'(full),       32'(e.full));
                check("used_count", 32'(used_count), 32'(e.used_pre));
                @(posedge clk);
                #1;
                check("error",           32'(error),      32'(e.err));
                check("used_count_post", 32'(used_count), 32'(e.used_post));
                check("full_post",       32'(full),       32'(e.full_post));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] idx;
        int r;
        int vc;
        m_clear();
        #2;
        check("rst_used",  32'(used_count), 32'd0);
        check("rst_full",  32'(full),       32'd0);
        check("rst_error", 32'(error),      32'd0);
        check("rst_hit",   32'(hit),        32'd0);
        check("rst_vout",  32'(value_out),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First store and lookup
        do_op(1, 0, 0, 8'h11, 16'hBEEF, '0);
        do_op(0, 0, 0, 8'h11, 16'h0000, '0);
        // Fill to capacity, overflow, then overwrite an existing key
        for (int i = 0; i < N - 1; i++) do_op(1, 0, 0, 8'h20 + 8'(i), 16'(16'h1000 + i), '0);
        do_op(1, 0, 0, 8'h99, 16'hDEAD, '0);
        do_op(1, 0, 0, 8'h11, 16'h1234, '0);
        do_op(0, 0, 0, 8'h11, 16'h0000, '0);
        // Delete cell 2 and exercise rejected requests
        do_op(0, 1, 0, 8'h00, 16'h0000, 16'h0004);
        do_op(0, 0, 0, 8'h21, 16'h0000, '0);
        do_op(0, 1, 0, 8'h00, 16'h0000, 16'h0004);
        do_op(0, 1, 0, 8'h00, 16'h0000, 16'h0006);
        do_op(1, 1, 0, 8'h21, 16'h5555, 16'h0008);
        do_op(1, 0, 0, 8'h55, 16'hCAFE, '0);
        do_op(0, 0, 1, 8'h00, 16'h0000, 16'h0004);
        do_op(1, 0, 1, 8'h66, 16'h7777, 16'h0000);

        // Randomised mix with a small key pool so hits, misses and overflow all occur
        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(0, 99);
            idx = N'(1) << $urandom_range(0, N - 1);
            if (r < 30)      do_op(1, 0, 0, 8'($urandom_range(0, 23)), 16'($urandom), '0);
            else if (r < 48) do_op(1, 0, 1, 8'($urandom_range(0, 23)), 16'($urandom), idx);
            else if (r < 72) do_op(0, 1, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 23)), 16'($urandom), idx);
            else if (r < 78) do_op($urandom_range(0, 1) == 1, 1'b0, 1'b1, 8'($urandom), 16'($urandom), 16'($urandom) & 16'($urandom));
            else if (r < 82) do_op(0, 1, 0, 8'($urandom), 16'($urandom), 16'($urandom_range(0, 1)) * 16'($urandom));
            else if (r < 86) do_op(1, 1, $urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom), idx);
            else             do_op(0, 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 23)), 16'($urandom), idx);
        end

        // Asynchronous reset during a key write to a non-full array
        vc = -1;
        for (int i = 0; i < N; i++) if (m_valid[i] && vc < 0) vc = i;
        if (m_count() == N) do_op(0, 1, 0, 8'h00, 16'h0000, N'(1) << vc);
        do_op(1, 1, 0, 8'h00, 16'h0000, 16'h0001);
        @(negedge clk);
        write_in = 1'b1; delete_in = 1'b0; select = 1'b0;
        key_in = 8'hF7; value_in = 16'hABCD; idx_in = '0;
        #1;
        check("error_before_rst", 32'(error), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_used",  32'(used_count), 32'd0);
        check("mid_rst_error", 32'(error),      32'd0);
        check("mid_rst_full",  32'(full),       32'd0);
        check("mid_rst_hit",   32'(hit),        32'd0);
        check("mid_rst_idx",   32'(hit_idx),    32'd0);
        check("mid_rst_vout",  32'(value_out),  32'd0);
        @(negedge clk);
        write_in = 1'b0;
        rst = 1'b0;
        m_clear();
        do_op(0, 0, 0, 8'hF7, 16'h0000, '0);
        do_op(1, 0, 0, 8'h42, 16'h4242, '0);
        do_op(0, 0, 1, 8'h00, 16'h0000, 16'h0001);
        idle();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_mem_block.md
CACHE_MEM_BLOCK -- requirements
Module: cache_mem_block

Interface
REQ-001 The module SHALL have parameter NUM_ENTRIES, default 16, giving the number of key/value cells.
REQ-002 The module SHALL have parameter KEY_WIDTH, default 8, giving the key width in bits.
REQ-003 The module SHALL have parameter VALUE_WIDTH, default 16, giving the value width in bits.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port key_in, input, KEY_WIDTH bits: the lookup key, or the key to store.
REQ-007 The module SHALL have port value_in, input, VALUE_WIDTH bits: the value to store.
REQ-008 The module SHALL have port select, input, 1 bit: 0 = key-based access, 1 = index-based access.
REQ-009 The module SHALL have port write_in, input, 1 bit: write request.
REQ-010 The module SHALL have port delete_in, input, 1 bit: delete request.
REQ-011 The module SHALL have port idx_in, input, NUM_ENTRIES bits: one-hot cell index for index-based access and for delete.
REQ-012 The module SHALL have port hit, output, 1 bit: a valid cell's key equals key_in.
REQ-013 The module SHALL have port hit_idx, output, NUM_ENTRIES bits: one-hot index of the matching cell.
REQ-014 The module SHALL have port value_out, output, VALUE_WIDTH bits: value of the addressed cell.
REQ-015 The module SHALL have port full, output, 1 bit: all cells are valid.
REQ-016 The module SHALL have port used_count, output, $clog2(NUM_ENTRIES+1) bits: the number of valid cells.
REQ-017 The module SHALL have port error, output, 1 bit: one-cycle registered pulse flagging a rejected request.

Function
REQ-018 hit and hit_idx SHALL be combinational from key_in and the cell array; only valid cells SHALL match.
REQ-019 When no cell matches, hit_idx SHALL be 0.
REQ-020 When several cells match (illegal state), hit_idx SHALL select only the lowest index.
REQ-021 value_out SHALL be combinational: the value at hit_idx when select=0, the value at idx_in when select=1, and 0 when nothing is addressed.
REQ-022 A key write (write_in=1, select=0) on a hit SHALL overwrite the value of the hit cell at the next edge; valid bits and used_count SHALL be unchanged.
REQ-023 A key write on a miss with full=0 SHALL store key_in/value_in in the lowest-index invalid cell, set its valid bit, and increment used_count.
REQ-024 A key write on a miss with full=1 SHALL leave the array unchanged and set error for one cycle.
REQ-025 An index write (write_in=1, select=1) with a one-hot idx_in SHALL store key_in/value_in at idx_in and set its valid bit; used_count SHALL increment only if the cell was previously invalid.
REQ-026 A delete (delete_in=1) with a one-hot idx_in addressing a valid cell SHALL clear that valid bit at the next edge and decrement used_count; stored key and value need not be cleared.
REQ-027 A delete addressing an invalid cell SHALL leave the array unchanged and set error.
REQ-028 Any request with an idx_in that is zero or not one-hot, where idx_in is used, SHALL leave the array unchanged and set error.
REQ-029 write_in=1 together with delete_in=1 SHALL leave the array unchanged and set error.
REQ-030 error SHALL be 1 only in the cycle after a rejected request and 0 otherwise.
REQ-031 used_count SHALL always equal the popcount of the valid bits and SHALL never wrap.
REQ-032 full SHALL be (used_count == NUM_ENTRIES).
REQ-033 All writes and deletes SHALL take effect in exactly one cycle; there is no busy state.

Reset
REQ-034 On rst=1, all valid bits, used_count and error SHALL clear immediately; full=0, hit=0, hit_idx=0, value_out=0.
REQ-035 Key and value storage SHALL need no reset.
REQ-036 A request in flight when rst asserts SHALL be discarded.

Structure
REQ-037 A mem_op_e enumeration (NOP, KEY_WRITE, IDX_WRITE, DELETE, ILLEGAL), decoded internally from write_in/select/delete_in, SHALL live in ctrl_types_pkg.
REQ-038 The lowest-index priority encoder SHALL be the sub-module first_set_enc (parameter WIDTH), used for both free-cell selection and hit_idx.
REQ-039 The one-hot legality check SHALL be local to this module.

Verification
REQ-040 Reset, then key-write key 0x11/value 0xBEEF: -> cell 0 valid, used_count=1; lookup 0x11 gives hit=1, hit_idx=0x0001, value_out=0xBEEF.
REQ-041 Fill 16 distinct keys, then key-write new key 0x99: -> full=1, error pulses for 1 cycle, used_count stays 16; rewrite an existing key with 0x1234 -> value updated, error=0.
REQ-042 Delete idx 0x0004 (valid): -> used_count decrements, lookup of that key gives hit=0; then key-write a new key -> it lands in cell 2.
REQ-043 Delete idx 0x0004 again (now invalid), delete idx 0x0006, and write_in+delete_in in the same cycle: -> each gives an error pulse, array and used_count unchanged.
REQ-044 Assert rst mid-cycle during a key write to a non-full array: -> valid bits, used_count and error clear asynchronously, and the write is not committed after rst releases.
